// File: rtl/dac_spi_tx.sv
// dac_spi_tx
//   SPI write master for the dual-channel 12-bit printhead bias/heater DAC
//   (AD5322-style 16-bit frame). Takes one channel/data write per valid/ready
//   handshake, shifts it out MSB first, optionally pulses LDAC afterwards, and
//   keeps a shadow copy of the last code completed on each channel.
//
//   Ports
//     clk48mhz    in   sole clock
//     rst         in   asynchronous active-high reset
//     wr_valid    in   write request
//     wr_ready    out  block can accept a write (IDLE)
//     wr_chan     in   0 = channel A, 1 = channel B
//     wr_data     in   12-bit DAC code
//     wr_load     in   pulse LDAC after this frame
//     dac_sclk    out  SPI clock, idles high, DAC samples on the falling edge
//     dac_din     out  SPI data
//     dac_sync_n  out  frame select, active low
//     dac_ldac_n  out  load strobe, active low
//     busy        out  frame in progress
//     frame_done  out  one-cycle pulse at the end of each write
//     last_a      out  last code completed on channel A
//     last_b      out  last code completed on channel B
module dac_spi_tx #(
    parameter int unsigned CLK_DIV    = 12,
    parameter int unsigned LDAC_WIDTH = 4
) (
    input  logic        clk48mhz,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic        wr_chan,
    input  logic [11:0] wr_data,
    input  logic        wr_load,
    output logic        dac_sclk,
    output logic        dac_din,
    output logic        dac_sync_n,
    output logic        dac_ldac_n,
    output logic        busy,
    output logic        frame_done,
    output logic [11:0] last_a,
    output logic [11:0] last_b
);

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] LDAC_LAST = 8'(LDAC_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP,
        S_LDAC,
        S_DONE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_div_cnt, w_div_nxt;
    logic [7:0]  r_ldac_cnt, w_ldac_nxt;
    logic [4:0]  r_half_cnt, w_half_nxt;   // SCLK half-period index inside SHIFT
    logic [15:0] r_shift, w_shift_nxt;
    logic        r_chan, w_chan_nxt;
    logic        r_load, w_load_nxt;
    logic [11:0] r_data, w_data_nxt;
    logic [11:0] r_last_a, w_last_a_nxt;
    logic [11:0] r_last_b, w_last_b_nxt;
    logic        w_tick;
    logic        w_frame_nxt;

    logic r_ready, r_busy, r_done, r_sclk, r_din, r_sync_n, r_ldac_n;

    assign w_tick = (r_div_cnt == DIV_LAST);

    always_comb begin
        w_state_nxt  = r_state;
        w_div_nxt    = '0;
        w_ldac_nxt   = r_ldac_cnt;
        w_half_nxt   = r_half_cnt;
        w_shift_nxt  = r_shift;
        w_chan_nxt   = r_chan;
        w_load_nxt   = r_load;
        w_data_nxt   = r_data;
        w_last_a_nxt = r_last_a;
        w_last_b_nxt = r_last_b;

        if (r_state != S_IDLE && !w_tick) begin
            w_div_nxt = r_div_cnt + 8'd1;
        end

        case (r_state)
            S_IDLE: begin
                if (wr_valid && r_ready) begin
                    w_state_nxt = S_SETUP;
                    w_shift_nxt = {wr_chan, 1'b0, 2'b00, wr_data};
                    w_chan_nxt  = wr_chan;
                    w_load_nxt  = wr_load;
                    w_data_nxt  = wr_data;
                    w_half_nxt  = '0;
                end
            end
            S_SETUP: begin
                if (w_tick) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_tick) begin
                    if (r_half_cnt == 5'd31) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_half_nxt = r_half_cnt + 5'd1;
                        // Even half = SCLK low, so this tick is a rising edge:
                        // present the next bit, except after the last falling
                        // edge where bit0 is held through HOLD.
                        if (!r_half_cnt[0] && r_half_cnt != 5'd30) begin
                            w_shift_nxt = {r_shift[14:0], 1'b0};
                        end
                    end
                end
            end
            S_HOLD: begin
                if (w_tick) w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (w_tick) begin
                    w_ldac_nxt  = '0;
                    w_state_nxt = r_load ? S_LDAC : S_DONE;
                end
            end
            S_LDAC: begin
                if (r_ldac_cnt == LDAC_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_ldac_nxt = r_ldac_cnt + 8'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                if (r_chan) w_last_b_nxt = r_data;
                else        w_last_a_nxt = r_data;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_state_nxt != r_state) w_div_nxt = '0;
    end

    assign w_frame_nxt = (w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT) ||
                         (w_state_nxt == S_HOLD);

    always_ff @(posedge clk48mhz or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Pin outputs are registered from the next-state decode so they change
    // glitch-free on the same edge the FSM enters the corresponding state.
    always_ff @(posedge clk48mhz or posedge rst) begin
        if (rst) begin
            r_div_cnt  <= '0;
            r_ldac_cnt <= '0;
            r_half_cnt <= '0;
            r_shift    <= '0;
            r_chan     <= 1'b0;
            r_load     <= 1'b0;
            r_data     <= '0;
            r_last_a   <= '0;
            r_last_b   <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sclk     <= 1'b1;
            r_din      <= 1'b0;
            r_sync_n   <= 1'b1;
            r_ldac_n   <= 1'b1;
        end else begin
            r_div_cnt  <= w_div_nxt;
            r_ldac_cnt <= w_ldac_nxt;
            r_half_cnt <= w_half_nxt;
            r_shift    <= w_shift_nxt;
            r_chan     <= w_chan_nxt;
            r_load     <= w_load_nxt;
            r_data     <= w_data_nxt;
            r_last_a   <= w_last_a_nxt;
            r_last_b   <= w_last_b_nxt;
            r_ready    <= (w_state_nxt == S_IDLE);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
            r_sclk     <= (w_state_nxt == S_SHIFT) ? w_half_nxt[0] : 1'b1;
            r_din      <= w_frame_nxt ? w_shift_nxt[15] : 1'b0;
            r_sync_n   <= !w_frame_nxt;
            r_ldac_n   <= (w_state_nxt != S_LDAC);
        end
    end

    assign wr_ready   = r_ready;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign dac_sclk   = r_sclk;
    assign dac_din    = r_din;
    assign dac_sync_n = r_sync_n;
    assign dac_ldac_n = r_ldac_n;
    assign last_a     = r_last_a;
    assign last_b     = r_last_b;

endmodule
